// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and field-presence helpers.
// Decode and execute reuse these.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH_OP,
        ST_FETCH_REG,
        ST_FETCH_C,
        ST_OUT,
        ST_WAIT_PC,
        ST_HALTED
    } fetch_state_e;

    function automatic logic need_regids(input logic [3:0] icode);
        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_OPQ, I_PUSHQ, I_POPQ: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic need_valC(input logic [3:0] icode);
        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/y86_imem_byte_port.sv
// Byte read port: drives the req/ack handshake for one byte and rejects addresses
// beyond the instruction memory without ever issuing them.
module y86_imem_byte_port #(
    parameter int MEM_BYTES = 4096
) (
    input  logic        rd_en,
    input  logic [63:0] rd_addr,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_data,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_ack,
    input  logic        imem_err
);

    logic in_range;

    // rd_addr comes straight from registered pc/byte counter, so req and addr hold
    // until the fetch FSM advances on rsp_valid.
    always_comb begin
        in_range  = rd_addr < 64'(MEM_BYTES);
        imem_req  = rd_en & in_range;
        imem_addr = imem_req ? rd_addr : 64'd0;
        rsp_valid = rd_en & (~in_range | imem_ack | imem_err);
        rsp_err   = rd_en & (~in_range | imem_err);
        rsp_data  = imem_rdata;
    end

endmodule

// File: rtl/y86_fetch_unit.sv
// Multi-cycle Y86-64 fetch: reads instruction bytes one per handshake, assembles
// icode/ifun/rA/rB/valC/valP/stat and hands them downstream.
module y86_fetch_unit
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] start_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [7:0]  imem_rdata,
    input  logic        imem_ack,
    input  logic        imem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [2:0]  stat,
    input  logic        pc_load,
    input  logic [63:0] pc_new,
    output logic        busy
);

    fetch_state_e state_q, state_d;
    logic [63:0]  pc_q, pc_d, valc_q, valc_d, valp_q, valp_d;
    logic [3:0]   icode_q, icode_d, ifun_q, ifun_d, ra_q, ra_d, rb_q, rb_d;
    logic [2:0]   stat_q, stat_d, cnt_q, cnt_d;
    logic         rd_en, rsp_valid, rsp_err;
    logic [7:0]   rsp_data;
    logic [3:0]   byte_off, op_icode;

    y86_imem_byte_port #(.MEM_BYTES(MEM_BYTES)) u_port (
        .rd_en     (rd_en),
        .rd_addr   (pc_q + {60'd0, byte_off}),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .imem_err  (imem_err)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valc_d   = valc_q;
        valp_d   = valp_q;
        icode_d  = icode_q;
        ifun_d   = ifun_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        stat_d   = stat_q;
        cnt_d    = cnt_q;
        op_icode = rsp_data[7:4];
        rd_en    = (state_q == ST_FETCH_OP) || (state_q == ST_FETCH_REG) ||
                   (state_q == ST_FETCH_C);
        case (state_q)
            ST_FETCH_REG: byte_off = 4'd1;
            ST_FETCH_C:   byte_off = 4'd1 + {3'd0, need_regids(icode_q)} + {1'b0, cnt_q};
            default:      byte_off = 4'd0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pc_d    = start_pc;
                    state_d = ST_FETCH_OP;
                end
            end
            ST_FETCH_OP: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        stat_d  = S_ADR;
                        state_d = ST_OUT;
                    end else begin
                        icode_d = op_icode;
                        ifun_d  = rsp_data[3:0];
                        valp_d  = pc_q + 64'd1 + {63'd0, need_regids(op_icode)} +
                                  (need_valC(op_icode) ? 64'd8 : 64'd0);
                        if (op_icode > I_POPQ) begin
                            stat_d  = S_INS;
                            state_d = ST_OUT;
                        end else if (need_regids(op_icode)) begin
                            state_d = ST_FETCH_REG;
                        end else if (need_valC(op_icode)) begin
                            cnt_d   = 3'd0;
                            state_d = ST_FETCH_C;
                        end else begin
                            if (op_icode == I_HALT) stat_d = S_HLT;
                            state_d = ST_OUT;
                        end
                    end
                end
            end
            ST_FETCH_REG: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        stat_d  = S_ADR;
                        state_d = ST_OUT;
                    end else begin
                        ra_d    = rsp_data[7:4];
                        rb_d    = rsp_data[3:0];
                        cnt_d   = 3'd0;
                        state_d = need_valC(icode_q) ? ST_FETCH_C : ST_OUT;
                    end
                end
            end
            ST_FETCH_C: begin
                if (rsp_valid) begin
                    if (rsp_err) begin
                        stat_d  = S_ADR;
                        state_d = ST_OUT;
                    end else begin
                        valc_d[{cnt_q, 3'b000} +: 8] = rsp_data;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) state_d = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) state_d = (stat_q == S_AOK) ? ST_WAIT_PC : ST_HALTED;
            end
            ST_WAIT_PC: begin
                // Fields return to their reset values so a short instruction never
                // carries stale rA/rB/valC from the previous one.
                if (pc_load) begin
                    pc_d    = pc_new;
                    valc_d  = 64'd0;
                    valp_d  = 64'd0;
                    icode_d = I_HALT;
                    ifun_d  = 4'd0;
                    ra_d    = RNONE;
                    rb_d    = RNONE;
                    stat_d  = S_AOK;
                    cnt_d   = 3'd0;
                    state_d = ST_FETCH_OP;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= 64'd0;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            icode_q <= I_HALT;
            ifun_q  <= 4'd0;
            ra_q    <= RNONE;
            rb_q    <= RNONE;
            stat_q  <= S_AOK;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            stat_q  <= stat_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign icode     = icode_q;
    assign ifun      = ifun_q;
    assign rA        = ra_q;
    assign rB        = rb_q;
    assign valC      = valc_q;
    assign valP      = valp_q;
    assign stat      = stat_q;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Directed bench for y86_fetch_unit: a full-size instance on a byte memory model with
// optional random ack delay, plus a 16-byte instance for the address-range case.
module tb_y86_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] start_pc = 64'd0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [7:0]  imem_rdata = 8'd0;
    logic        imem_ack, imem_err;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [2:0]  stat;
    logic        pc_load = 1'b0;
    logic [63:0] pc_new = 64'd0;
    logic        busy;

    logic        start16 = 1'b0;
    logic [63:0] start_pc16 = 64'd0;
    logic        req16;
    logic [63:0] addr16;
    logic [7:0]  rdata16 = 8'd0;
    logic        ack16_q = 1'b0;
    logic        err16 = 1'b0;
    logic        valid16;
    logic        ready16 = 1'b1;
    logic [3:0]  icode16, ifun16, ra16, rb16;
    logic [63:0] valc16, valp16;
    logic [2:0]  stat16;
    logic        pc_load16 = 1'b0;
    logic [63:0] pc_new16 = 64'd0;
    logic        busy16;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    y86_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .start_pc(start_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .imem_err(imem_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .stat(stat), .pc_load(pc_load), .pc_new(pc_new), .busy(busy)
    );

    y86_fetch_unit #(.MEM_BYTES(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .start_pc(start_pc16),
        .imem_req(req16), .imem_addr(addr16), .imem_rdata(rdata16),
        .imem_ack(ack16_q), .imem_err(err16),
        .out_valid(valid16), .out_ready(ready16),
        .icode(icode16), .ifun(ifun16), .rA(ra16), .rB(rb16), .valC(valc16), .valP(valp16),
        .stat(stat16), .pc_load(pc_load16), .pc_new(pc_new16), .busy(busy16)
    );

    // Memory model for the full-size instance
    logic [7:0]  mem [0:255];
    logic [7:0]  mem16 [0:15];
    int          delay_max = 0;
    int          wait_cnt = 0;
    logic        ack_q = 1'b0;
    logic        err_mode = 1'b0;
    logic        stray = 1'b0;
    int          req_count = 0;
    int          stab_err = 0;
    logic        req_prev = 1'b0;
    logic        done_prev = 1'b0;
    logic [63:0] addr_prev = 64'd0;
    int          req_count16 = 0;
    int          bad16 = 0;

    assign imem_ack = ack_q | stray;
    assign imem_err = ack_q & err_mode;

    always @(posedge clk) begin
        if (imem_req && (imem_ack || imem_err)) req_count <= req_count + 1;
        if (imem_req && !ack_q) begin
            if (wait_cnt == 0) begin
                ack_q      <= 1'b1;
                imem_rdata <= mem[imem_addr[7:0]];
            end else begin
                wait_cnt <= wait_cnt - 1;
            end
        end else begin
            ack_q    <= 1'b0;
            wait_cnt <= (delay_max == 0) ? 0 : int'($urandom_range(delay_max, 0));
        end
        if (req_prev && !done_prev && imem_req && (imem_addr != addr_prev))
            stab_err <= stab_err + 1;
        req_prev  <= imem_req;
        addr_prev <= imem_addr;
        done_prev <= imem_ack | imem_err;
    end

    always @(posedge clk) begin
        if (req16 && ack16_q) req_count16 <= req_count16 + 1;
        if (req16 && (addr16 >= 64'd16)) bad16 <= bad16 + 1;
        if (req16 && !ack16_q) begin
            ack16_q <= 1'b1;
            rdata16 <= mem16[addr16[3:0]];
        end else begin
            ack16_q <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic [63:0] pc);
        start_pc = pc;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!out_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) check("wait_valid_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int cyc;
        int base;
        int sbase;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 16; i++) mem16[i] = 8'h00;
        mem[0] = 8'h30; mem[1] = 8'hF0; mem[2] = 8'hEF; mem[3] = 8'hCD; mem[4] = 8'hAB;
        mem[5] = 8'h89; mem[6] = 8'h67; mem[7] = 8'h45; mem[8] = 8'h23; mem[9] = 8'h01;
        mem[8'h20] = 8'h10; mem[8'h21] = 8'h60; mem[8'h22] = 8'h23;
        mem[8'h40] = 8'h10; mem[8'h50] = 8'h10;
        mem16[12] = 8'h70;

        repeat (2) @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_icode", 64'(icode), 64'd0);
        check("rst_ifun", 64'(ifun), 64'd0);
        check("rst_rA", 64'(rA), 64'hF);
        check("rst_rB", 64'(rB), 64'hF);
        check("rst_valC", valC, 64'd0);
        check("rst_valP", valP, 64'd0);
        check("rst_stat", 64'(stat), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // irmovq, zero-wait memory
        base = req_count;
        pulse_start(64'd0);
        wait_valid(60, cyc);
        check("irmovq_latency", 64'(cyc), 64'd20);
        check("irmovq_icode", 64'(icode), 64'd3);
        check("irmovq_ifun", 64'(ifun), 64'd0);
        check("irmovq_rA", 64'(rA), 64'hF);
        check("irmovq_rB", 64'(rB), 64'h0);
        check("irmovq_valC", valC, 64'h0123456789ABCDEF);
        check("irmovq_valP", valP, 64'd10);
        check("irmovq_stat", 64'(stat), 64'd1);
        check("irmovq_reqs", 64'(req_count - base), 64'd10);
        @(negedge clk);
        check("irmovq_xfer_valid", 64'(out_valid), 64'd0);
        check("irmovq_waitpc_busy", 64'(busy), 64'd1);

        // nop then addq via pc_load
        do_reset();
        pulse_start(64'h20);
        wait_valid(40, cyc);
        check("nop_icode", 64'(icode), 64'd1);
        check("nop_valP", valP, 64'h21);
        @(negedge clk);
        pc_new  = 64'h21;
        pc_load = 1'b1;
        @(negedge clk);
        pc_load = 1'b0;
        wait_valid(40, cyc);
        check("addq_icode", 64'(icode), 64'd6);
        check("addq_ifun", 64'(ifun), 64'd0);
        check("addq_rA", 64'(rA), 64'd2);
        check("addq_rB", 64'(rB), 64'd3);
        check("addq_valC", valC, 64'd0);
        check("addq_valP", valP, 64'h23);

        // invalid opcode then HALTED
        mem[0] = 8'hC0;
        do_reset();
        base = req_count;
        pulse_start(64'd0);
        wait_valid(40, cyc);
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_icode", 64'(icode), 64'hC);
        check("ins_reqs", 64'(req_count - base), 64'd1);
        @(negedge clk);
        check("ins_halted_busy", 64'(busy), 64'd0);
        pc_new  = 64'h20;
        pc_load = 1'b1;
        start   = 1'b1;
        repeat (3) @(negedge clk);
        pc_load = 1'b0;
        start   = 1'b0;
        check("ins_halted_req", 64'(imem_req), 64'd0);
        check("ins_halted_valid", 64'(out_valid), 64'd0);
        check("ins_halted_reqs", 64'(req_count - base), 64'd1);
        mem[0] = 8'h30;

        // ack and err together: err wins
        err_mode = 1'b1;
        do_reset();
        pulse_start(64'h50);
        wait_valid(40, cyc);
        check("err_stat", 64'(stat), 64'd3);
        check("err_icode", 64'(icode), 64'd0);
        check("err_valP", valP, 64'd0);
        err_mode = 1'b0;

        // random ack delays with downstream back-pressure
        delay_max = 5;
        out_ready = 1'b0;
        do_reset();
        base  = req_count;
        sbase = stab_err;
        pulse_start(64'd0);
        wait_valid(400, cyc);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_valC", valC, 64'h0123456789ABCDEF);
            check("bp_rB", 64'(rB), 64'h0);
            @(negedge clk);
        end
        check("bp_valP", valP, 64'd10);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_xfer_valid", 64'(out_valid), 64'd0);
        check("bp_reqs", 64'(req_count - base), 64'd10);
        check("bp_addr_stable", 64'(stab_err - sbase), 64'd0);
        delay_max = 0;

        // reset during FETCH_C byte 4
        do_reset();
        pulse_start(64'd0);
        cyc = 0;
        while (!(imem_req && imem_addr == 64'd6) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("midrst_reach", imem_addr, 64'd6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", 64'(imem_req), 64'd0);
        check("midrst_addr", imem_addr, 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_valC", valC, 64'd0);
        check("midrst_rB", 64'(rB), 64'hF);
        check("midrst_icode", 64'(icode), 64'd0);
        rst   = 1'b0;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_valid", 64'(out_valid), 64'd0);
        pulse_start(64'h40);
        check("restart_req", 64'(imem_req), 64'd1);
        check("restart_addr", imem_addr, 64'h40);
        wait_valid(40, cyc);
        check("restart_icode", 64'(icode), 64'd1);
        check("restart_valP", valP, 64'h41);

        // 16-byte memory: jmp at 12 runs off the end
        start_pc16 = 64'd12;
        start16    = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        cyc = 0;
        while (!valid16 && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check("adr_valid", 64'(valid16), 64'd1);
        check("adr_stat", 64'(stat16), 64'd3);
        check("adr_icode", 64'(icode16), 64'd7);
        check("adr_valC", valc16, 64'd0);
        check("adr_no_req16", 64'(bad16), 64'd0);
        check("adr_reqs", 64'(req_count16), 64'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
